// File: rtl/if_prefetch_buffer_if.sv
// rtl/if_prefetch_buffer_if.sv - fetch control, instruction-memory and decode-side signals of the prefetch buffer
interface if_prefetch_buffer_if;
  logic [29:0] boot_addr_i;
  logic        fetch_en_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic        busy_o;

  // master: the prefetch buffer itself
  modport master (
    input  boot_addr_i, fetch_en_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           branch_i, branch_addr_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, busy_o
  );

  // slave: instruction memory, branch unit and decode stage around it
  modport slave (
    output boot_addr_i, fetch_en_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           branch_i, branch_addr_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, busy_o
  );
endinterface

// File: rtl/if_prefetch_buffer.sv
// rtl/if_prefetch_buffer.sv - instruction prefetch FIFO with in-order fetch tracking and branch discard
// Define IF_PREFETCH_BYPASS_EN to forward a response into an empty FIFO straight to decode.
module if_prefetch_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  if_prefetch_buffer_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e         state;
  logic [31:0]    fetch_addr;
  logic           addr_loaded;
  logic [31:0]    resp_pc;
  logic           pc_loaded;
  logic [CW-1:0]  count;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  discard;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [31:0]    mem_instr [DEPTH];
  logic [31:0]    mem_pc    [DEPTH];

  logic [31:0]    boot_byte;
  logic [31:0]    cur_addr;
  logic [31:0]    cur_pc;
  logic [31:0]    branch_tgt;
  logic [CW:0]    space_used;
  logic [CW-1:0]  out_next;
  logic           req;
  logic           gnt_fire;
  logic           rvalid_fire;
  logic           resp_keep;
  logic           head_valid;
  logic           out_valid;
  logic           bypass_take;
  logic           push;
  logic           pop;
  logic [31:0]    instr_d;
  logic [31:0]    pc_d;

  // Boot address is only followed until the first grant/branch, so reset stays constant.
  assign boot_byte  = {bus.boot_addr_i, 2'b00};
  assign cur_addr   = addr_loaded ? fetch_addr : boot_byte;
  assign cur_pc     = pc_loaded ? resp_pc : boot_byte;
  assign branch_tgt = bus.branch_addr_i & ~32'h3;

  // Pending discards still occupy FIFO space until their responses drain.
  assign space_used  = {1'b0, count} + {1'b0, outstanding};
  assign req         = (state == RUN) && bus.fetch_en_i && (space_used < DEPTH_S);
  assign gnt_fire    = req && bus.imem_gnt_i;
  assign rvalid_fire = bus.imem_rvalid_i && (outstanding != '0);
  assign resp_keep   = rvalid_fire && (discard == '0);
  assign out_next    = outstanding + CW'(gnt_fire) - CW'(rvalid_fire);
  assign head_valid  = (count != '0);

`ifdef IF_PREFETCH_BYPASS_EN
  logic byp_valid;
  assign byp_valid   = resp_keep && !head_valid;
  assign bypass_take = byp_valid && bus.instr_ready_i && !bus.branch_i;
  assign out_valid   = head_valid || byp_valid;
`else
  assign bypass_take = 1'b0;
  assign out_valid   = head_valid;
`endif

  assign push = resp_keep && !bus.branch_i && !bypass_take;
  assign pop  = head_valid && bus.instr_ready_i && !bus.branch_i;

  always_comb begin
    instr_d = '0;
    pc_d    = '0;
    if (head_valid) begin
      instr_d = mem_instr[rd_ptr];
      pc_d    = mem_pc[rd_ptr];
    end
`ifdef IF_PREFETCH_BYPASS_EN
    else if (byp_valid) begin
      instr_d = bus.imem_rdata_i;
      pc_d    = cur_pc;
    end
`endif
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = cur_addr;
  assign bus.instr_valid_o = out_valid && !bus.branch_i;
  assign bus.instr_o       = instr_d;
  assign bus.pc_o          = pc_d;
  assign bus.busy_o        = head_valid || (outstanding != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      fetch_addr  <= '0;
      addr_loaded <= 1'b0;
      resp_pc     <= '0;
      pc_loaded   <= 1'b0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      case (state)
        IDLE:    if (bus.fetch_en_i) state <= RUN;
        RUN:     if (!bus.fetch_en_i && (outstanding == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase

      outstanding <= out_next;

      if (bus.branch_i) begin
        // Everything still in flight, including a grant taken this cycle, belongs to the old path.
        discard     <= out_next;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        fetch_addr  <= branch_tgt;
        addr_loaded <= 1'b1;
        resp_pc     <= branch_tgt;
        pc_loaded   <= 1'b1;
      end else begin
        if (rvalid_fire && (discard != '0)) discard <= discard - 1'b1;
        count  <= count + CW'(push) - CW'(pop);
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_ptr + PW'(pop);
        if (gnt_fire) begin
          fetch_addr  <= cur_addr + 32'd4;
          addr_loaded <= 1'b1;
        end
        if (resp_keep) begin
          resp_pc   <= cur_pc + 32'd4;
          pc_loaded <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.imem_rdata_i;
      mem_pc[wr_ptr]    <= cur_pc;
    end
  end

endmodule
